// File: rtl/wb_burst_master.sv
// wb_burst_master: Wishbone B3 burst master turning app commands and a write stream into
// classic/incremental bursts, returning read data as a stream, with stalled-ack timeout abort.
module wb_burst_master #(
  parameter int AW      = 26,
  parameter int DW      = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_we,
  input  logic [AW-1:0]   cmd_addr,
  input  logic [7:0]      cmd_len,
  input  logic            wr_valid,
  output logic            wr_ready,
  input  logic [DW-1:0]   wr_data,
  output logic            rd_valid,
  output logic [DW-1:0]   rd_data,
  output logic            rd_last,
  output logic            busy,
  output logic            err,
  output logic            wb_cyc_o,
  output logic            wb_stb_o,
  output logic            wb_we_o,
  output logic [AW-1:0]   wb_addr_o,
  output logic [DW/8-1:0] wb_sel_o,
  output logic [DW-1:0]   wb_dat_o,
  output logic [2:0]      wb_cti_o,
  input  logic [DW-1:0]   wb_dat_i,
  input  logic            wb_ack_i
);
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam int SW = DW / 8;
  typedef enum logic [1:0] {IDLE, WR, RD} state_t;
  state_t state, state_n;
  logic [8:0] beats_left, loads_left;
  logic [TW-1:0] tmo;
  logic hit, stall, abort, last, load, stb_n;
  always_comb begin
    hit       = wb_cyc_o && wb_stb_o && wb_ack_i;
    stall     = wb_stb_o && !wb_ack_i;
    abort     = stall && (tmo == TW'(TIMEOUT - 1));
    last      = hit && (beats_left == 9'd1);
    cmd_ready = state == IDLE;
    wr_ready  = (state == WR) && !wb_stb_o && (loads_left != 9'd0);
    load      = wr_valid && wr_ready;
    state_n   = state;
    stb_n     = wb_stb_o;
    if (state == IDLE) begin
      state_n = cmd_valid ? (cmd_we ? WR : RD) : IDLE;
      stb_n   = cmd_valid && !cmd_we;
    end else if (last || abort) begin
      state_n = IDLE;
      stb_n   = 1'b0;
    end else begin
      stb_n = hit ? (state == RD) : (load ? 1'b1 : wb_stb_o);
    end
  end
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) state <= IDLE;
    else state <= state_n;
  // In WR the strobe doubles as the "data register full" flag.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wb_cyc_o   <= 1'b0;
      wb_stb_o   <= 1'b0;
      wb_we_o    <= 1'b0;
      wb_addr_o  <= '0;
      wb_sel_o   <= '0;
      wb_dat_o   <= '0;
      wb_cti_o   <= 3'b000;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
      rd_last    <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
      beats_left <= '0;
      loads_left <= '0;
      tmo        <= '0;
    end else begin
      wb_stb_o <= stb_n;
      wb_sel_o <= {SW{stb_n}};
      busy     <= state_n != IDLE;
      rd_valid <= hit && (state == RD);
      rd_last  <= last && (state == RD);
      if (hit && (state == RD)) rd_data <= wb_dat_i;
      if (state == IDLE && cmd_valid) begin
        wb_cyc_o   <= 1'b1;
        wb_we_o    <= cmd_we;
        wb_addr_o  <= cmd_addr & ~AW'(3);
        beats_left <= {1'b0, cmd_len} + 9'd1;
        loads_left <= cmd_we ? {1'b0, cmd_len} + 9'd1 : 9'd0;
        wb_cti_o   <= cmd_we ? 3'b000 : ((cmd_len == 8'd0) ? 3'b111 : 3'b010);
        err        <= 1'b0;
        tmo        <= '0;
      end
      if (load) begin
        wb_dat_o   <= wr_data;
        loads_left <= loads_left - 9'd1;
        wb_cti_o   <= (loads_left == 9'd1) ? 3'b111 : 3'b010;
      end
      if (hit) begin
        wb_addr_o  <= wb_addr_o + AW'(4);
        beats_left <= beats_left - 9'd1;
        tmo        <= '0;
        if (state == RD) wb_cti_o <= (beats_left == 9'd2) ? 3'b111 : 3'b010;
      end else if (stall) begin
        tmo <= tmo + TW'(1);
      end
      if (last || abort) begin
        wb_cyc_o <= 1'b0;
        wb_we_o  <= 1'b0;
        wb_cti_o <= 3'b000;
      end
      if (abort) begin
        err <= 1'b1;
        tmo <= '0;
      end
    end
  end
endmodule

// File: tb/tb_wb_burst_master.sv
// tb_wb_burst_master: scoreboard bench with a memory-backed Wishbone slave model.
module tb_wb_burst_master;
  localparam int AW = 26, DW = 32, TMO = 16;
  typedef struct packed {logic we; logic [AW-1:0] addr; logic [DW-1:0] data; logic [2:0] cti; logic [3:0] sel;} beat_t;
  typedef struct packed {logic [DW-1:0] data; logic last; logic lat;} rd_t;
  logic wb_clk_i = 1'b0, wb_rst_i, cmd_valid, cmd_ready, cmd_we, wr_valid, wr_ready;
  logic rd_valid, rd_last, busy, err, wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i, ack_en;
  logic [AW-1:0] cmd_addr, wb_addr_o;
  logic [7:0] cmd_len;
  logic [DW-1:0] wr_data, rd_data, wb_dat_o, wb_dat_i;
  logic [3:0] wb_sel_o;
  logic [2:0] wb_cti_o;
  logic [31:0] mem [256];
  logic [255:0] written = '0;
  beat_t exp_q[$], ob_q[$];
  rd_t exp_rd[$], ob_rd[$];
  int gap_q[$];
  int ob_i = 0, rd_i = 0, checks = 0, errors = 0;
  int stb_cycles = 0, cyc_wait = 0, cyc_falls = 0, hit_cnt = 0, low_run = 0;
  logic prev_hit = 1'b0, cyc_prev = 1'b0;

  wb_burst_master #(.AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_we(cmd_we), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .wr_data(wr_data), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_last(rd_last), .busy(busy), .err(err), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_we_o(wb_we_o), .wb_addr_o(wb_addr_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o),
    .wb_cti_o(wb_cti_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i));

  always #5 wb_clk_i = ~wb_clk_i;

  function automatic logic [31:0] pat(input logic [7:0] i);
    return 32'hC0DE0000 | {24'h0, i};
  endfunction

  assign wb_ack_i = wb_cyc_o && wb_stb_o && ack_en;
  assign wb_dat_i = written[wb_addr_o[9:2]] ? mem[wb_addr_o[9:2]] : pat(wb_addr_o[9:2]);

  always @(posedge wb_clk_i)
    if (wb_ack_i && wb_we_o) begin
      mem[wb_addr_o[9:2]]     <= wb_dat_o;
      written[wb_addr_o[9:2]] <= 1'b1;
    end

  always @(negedge wb_clk_i) begin
    if (wb_ack_i) ob_q.push_back(beat_t'({wb_we_o, wb_addr_o, wb_we_o ? wb_dat_o : wb_dat_i, wb_cti_o, wb_sel_o}));
    if (rd_valid) ob_rd.push_back(rd_t'({rd_data, rd_last, prev_hit}));
    if (wb_cyc_o && !cyc_prev) gap_q.push_back(low_run);
    prev_hit   <= wb_ack_i;
    hit_cnt    <= hit_cnt + int'(wb_ack_i);
    stb_cycles <= stb_cycles + int'(wb_stb_o);
    cyc_wait   <= cyc_wait + int'(wb_cyc_o && !wb_stb_o);
    cyc_falls  <= cyc_falls + int'(!wb_cyc_o && cyc_prev);
    low_run    <= wb_cyc_o ? 0 : low_run + 1;
    cyc_prev   <= wb_cyc_o;
  end

  task automatic send_cmd(input logic we, input logic [AW-1:0] a, input logic [7:0] len, input logic hold);
    logic r;
    int n = 0;
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_len = len;
    do begin r = cmd_ready; @(posedge wb_clk_i); #1; n++; end while (!r && n < 200);
    if (!r) begin checks++; errors++; $display("FAIL cmd_accept timed out addr=%h", a); end
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic push_wr(input logic [DW-1:0] d, input int gap);
    logic r;
    int n = 0;
    wr_valid = 1'b1; wr_data = d;
    do begin r = wr_ready; @(posedge wb_clk_i); #1; n++; end while (!r && n < 200);
    if (!r) begin checks++; errors++; $display("FAIL wr_accept timed out data=%h", d); end
    wr_valid = 1'b0;
    repeat (gap) begin @(posedge wb_clk_i); #1; end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 500) begin @(posedge wb_clk_i); #1; n++; end
    if (busy) begin checks++; errors++; $display("FAIL idle timed out busy=%b", busy); end
    repeat (2) begin @(posedge wb_clk_i); #1; end
  endtask

  task automatic test_reset();
    wb_rst_i = 1'b1;
    repeat (3) @(posedge wb_clk_i);
    #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_cmd_ready got %b exp 1", cmd_ready); end
    checks++; if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_cti_o, wb_sel_o} !== 10'h0) begin errors++; $display("FAIL rst_bus got %b%b%b %b %h exp 0", wb_cyc_o, wb_stb_o, wb_we_o, wb_cti_o, wb_sel_o); end
    checks++; if (wb_addr_o !== '0) begin errors++; $display("FAIL rst_addr got %h exp 0", wb_addr_o); end
    checks++; if ({busy, err, rd_valid, rd_last, wr_ready} !== 5'b0) begin errors++; $display("FAIL rst_status got %b exp 00000", {busy, err, rd_valid, rd_last, wr_ready}); end
    wb_rst_i = 1'b0;
    @(posedge wb_clk_i); #1;
  endtask

  task automatic test_single_write();
    beat_t e, o;
    exp_q.push_back(beat_t'({1'b1, AW'('h100), 32'hDEADBEEF, 3'b111, 4'hF}));
    send_cmd(1'b1, AW'('h100), 8'd0, 1'b0);
    push_wr(32'hDEADBEEF, 0);
    wait_idle();
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = (ob_i < ob_q.size()) ? ob_q[ob_i] : '0;
      ob_i++;
      checks++; if (o !== e) begin errors++; $display("FAIL single_write_beat got %h exp %h", o, e); end
    end
    checks++; if (ob_i != ob_q.size()) begin errors++; $display("FAIL single_write_count got %0d exp %0d", ob_q.size(), ob_i); ob_i = ob_q.size(); end
    checks++; if (mem[8'h40] !== 32'hDEADBEEF) begin errors++; $display("FAIL single_write_mem got %h exp deadbeef", mem[8'h40]); end
  endtask

  task automatic test_burst_write();
    beat_t e, o;
    int cw0 = cyc_wait, cf0 = cyc_falls;
    for (int i = 0; i < 4; i++)
      exp_q.push_back(beat_t'({1'b1, AW'('h200 + 4 * i), 32'h11110000 + i, (i == 3) ? 3'b111 : 3'b010, 4'hF}));
    send_cmd(1'b1, AW'('h203), 8'd3, 1'b0);
    for (int i = 0; i < 4; i++) push_wr(32'h11110000 + i, (i == 1) ? 5 : 0);
    wait_idle();
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = (ob_i < ob_q.size()) ? ob_q[ob_i] : '0;
      ob_i++;
      checks++; if (o !== e) begin errors++; $display("FAIL burst_write_beat got %h exp %h", o, e); end
    end
    checks++; if (ob_i != ob_q.size()) begin errors++; $display("FAIL burst_write_count got %0d exp %0d", ob_q.size(), ob_i); ob_i = ob_q.size(); end
    checks++; if (cyc_wait - cw0 < 5) begin errors++; $display("FAIL burst_write_wait got %0d exp >=5", cyc_wait - cw0); end
    checks++; if (cyc_falls - cf0 != 1) begin errors++; $display("FAIL burst_write_cyc_held got %0d drops exp 1", cyc_falls - cf0); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (mem[8'h80 + i] !== 32'h11110000 + i) begin errors++; $display("FAIL burst_write_mem[%0d] got %h exp %h", i, mem[8'h80 + i], 32'h11110000 + i); end
    end
  endtask

  task automatic test_burst_read();
    beat_t e, o;
    rd_t re, ro;
    logic [31:0] d;
    for (int i = 0; i < 8; i++) begin
      d = (i < 4) ? 32'h11110000 + i : pat(8'h80 + 8'(i));
      exp_q.push_back(beat_t'({1'b0, AW'('h200 + 4 * i), d, (i == 7) ? 3'b111 : 3'b010, 4'hF}));
      exp_rd.push_back(rd_t'({d, i == 7, 1'b1}));
    end
    send_cmd(1'b0, AW'('h200), 8'd7, 1'b0);
    wait_idle();
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = (ob_i < ob_q.size()) ? ob_q[ob_i] : '0;
      ob_i++;
      checks++; if (o !== e) begin errors++; $display("FAIL burst_read_beat got %h exp %h", o, e); end
    end
    while (exp_rd.size() != 0) begin
      re = exp_rd.pop_front();
      ro = (rd_i < ob_rd.size()) ? ob_rd[rd_i] : '0;
      rd_i++;
      checks++; if (ro !== re) begin errors++; $display("FAIL burst_read_data got %h exp %h", ro, re); end
    end
    checks++; if (rd_i != ob_rd.size() || ob_i != ob_q.size()) begin errors++; $display("FAIL burst_read_count got %0d/%0d exp %0d/%0d", ob_rd.size(), ob_q.size(), rd_i, ob_i); rd_i = ob_rd.size(); ob_i = ob_q.size(); end
  endtask

  task automatic test_timeout();
    beat_t e, o;
    int s0 = stb_cycles;
    ack_en = 1'b0;
    send_cmd(1'b0, AW'('h40), 8'd3, 1'b0);
    wait_idle();
    checks++; if (stb_cycles - s0 != TMO) begin errors++; $display("FAIL timeout_stb_cycles got %0d exp %0d", stb_cycles - s0, TMO); end
    checks++; if ({err, busy, wb_cyc_o, wb_stb_o} !== 4'b1000) begin errors++; $display("FAIL timeout_flags got %b exp 1000", {err, busy, wb_cyc_o, wb_stb_o}); end
    checks++; if (ob_rd.size() != rd_i || ob_q.size() != ob_i) begin errors++; $display("FAIL timeout_no_data got %0d rd exp 0", ob_rd.size() - rd_i); rd_i = ob_rd.size(); ob_i = ob_q.size(); end
    ack_en = 1'b1;
    exp_q.push_back(beat_t'({1'b1, AW'('h40), 32'h55AA55AA, 3'b111, 4'hF}));
    send_cmd(1'b1, AW'('h40), 8'd0, 1'b0);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL timeout_err_clear got %b exp 0", err); end
    push_wr(32'h55AA55AA, 0);
    wait_idle();
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = (ob_i < ob_q.size()) ? ob_q[ob_i] : '0;
      ob_i++;
      checks++; if (o !== e) begin errors++; $display("FAIL timeout_next_beat got %h exp %h", o, e); end
    end
  endtask

  task automatic test_reset_mid();
    int h0 = hit_cnt, n = 0, r0;
    send_cmd(1'b0, AW'('h200), 8'd7, 1'b0);
    while (hit_cnt - h0 < 2 && n < 100) begin @(posedge wb_clk_i); #1; n++; end
    checks++; if (hit_cnt - h0 < 2) begin errors++; $display("FAIL reset_mid_beats got %0d exp 2", hit_cnt - h0); end
    wb_rst_i = 1'b1;
    #1;
    checks++; if ({wb_cyc_o, wb_stb_o, rd_valid, busy} !== 4'b0) begin errors++; $display("FAIL reset_mid_drop got %b exp 0000", {wb_cyc_o, wb_stb_o, rd_valid, busy}); end
    r0 = ob_rd.size();
    repeat (2) @(posedge wb_clk_i);
    #1 wb_rst_i = 1'b0;
    repeat (3) @(posedge wb_clk_i);
    #1;
    checks++; if (ob_rd.size() != r0 || wb_cyc_o !== 1'b0) begin errors++; $display("FAIL reset_mid_quiet got %0d rd cyc=%b exp 0 0", ob_rd.size() - r0, wb_cyc_o); end
    ob_i = ob_q.size();
    rd_i = ob_rd.size();
  endtask

  task automatic test_back_to_back();
    beat_t e, o;
    rd_t re, ro;
    int base = gap_q.size();
    for (int i = 0; i < 4; i++)
      exp_q.push_back(beat_t'({1'b1, AW'('h300 + 4 * i), 32'hB2B00000 + i, (i == 3) ? 3'b111 : 3'b010, 4'hF}));
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(beat_t'({1'b0, AW'('h300 + 4 * i), 32'hB2B00000 + i, (i == 3) ? 3'b111 : 3'b010, 4'hF}));
      exp_rd.push_back(rd_t'({32'hB2B00000 + i, i == 3, 1'b1}));
    end
    fork
      begin send_cmd(1'b1, AW'('h300), 8'd3, 1'b1); send_cmd(1'b0, AW'('h300), 8'd3, 1'b0); end
      for (int i = 0; i < 4; i++) push_wr(32'hB2B00000 + i, 0);
    join
    wait_idle();
    checks++; if (gap_q.size() < base + 2 || gap_q[base + 1] != 1) begin errors++; $display("FAIL b2b_idle_gap got %0d exp 1", (gap_q.size() < base + 2) ? -1 : gap_q[base + 1]); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = (ob_i < ob_q.size()) ? ob_q[ob_i] : '0;
      ob_i++;
      checks++; if (o !== e) begin errors++; $display("FAIL b2b_beat got %h exp %h", o, e); end
    end
    while (exp_rd.size() != 0) begin
      re = exp_rd.pop_front();
      ro = (rd_i < ob_rd.size()) ? ob_rd[rd_i] : '0;
      rd_i++;
      checks++; if (ro !== re) begin errors++; $display("FAIL b2b_read got %h exp %h", ro, re); end
    end
  endtask

  initial begin
    wb_rst_i = 1'b1; ack_en = 1'b1;
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0;
    test_reset();
    test_single_write();
    test_burst_write();
    test_burst_read();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
